// File: rtl/hazard_pkg.sv
// Shared types and sizes for the hazard scheduler and its MUL/DIV sequencer.
package hazard_pkg;

  localparam int REG_CNT = 32;
  localparam int REG_AW  = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESULT
  } md_state_t;

endpackage

// File: rtl/hazard_scheduler_md_sequencer.sv
// MUL/DIV sequencer: start pulse, latency count, write-port grant and
// starvation tracking for a pending result.
module md_sequencer
  import hazard_pkg::*;
#(
  parameter int MD_LAT     = 34,
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_accept,
  input  logic i_pipe_wb_valid,
  output logic o_md_start,
  output logic o_md_busy,
  output logic o_md_wb_grant,
  output logic o_starve
);

  localparam int             WW       = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [WW-1:0]  LIM      = WW'(STARVE_LIM);
  localparam logic [7:0]     LAT_LOAD = 8'(MD_LAT - 1);

  md_state_t      r_state;
  logic [7:0]     r_lat_cnt;
  logic [WW-1:0]  r_wait_cnt;

  // Sequencer FSM: latency countdown, then hold the result until the write port is won.
  // BUSY is left as the count steps to zero, so the result is valid MD_LAT cycles after md_start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_lat_cnt  <= '0;
      r_wait_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_accept) begin
            r_state   <= BUSY;
            r_lat_cnt <= LAT_LOAD;
          end
        end
        BUSY: begin
          r_lat_cnt <= r_lat_cnt - 8'd1;
          if (r_lat_cnt == 8'd1) begin
            r_state    <= RESULT;
            r_wait_cnt <= '0;
          end
        end
        RESULT: begin
          if (!i_pipe_wb_valid) begin
            r_state <= IDLE;
          end else if (r_wait_cnt < LIM) begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_md_start    = i_accept;
  assign o_md_busy     = (r_state != IDLE);
  assign o_md_wb_grant = (r_state == RESULT) && !i_pipe_wb_valid;
  assign o_starve      = (r_state == RESULT) && (r_wait_cnt >= LIM);

endmodule

// File: rtl/hazard_scheduler.sv
// Central hazard controller: stall/flush generation, MUL/DIV scoreboard and
// register-file write-port arbitration. Optional perf counters: HAZARD_PERF_EN.
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int MD_LAT     = 34,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic              md_op_id,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              load_ex,
  input  logic              mispredict_ex,
  input  logic              pipe_wb_valid,
  output logic              stall,
  output logic              flush,
  output logic              md_start,
  output logic              md_busy,
  output logic              md_wb_grant,
  output logic [REG_AW-1:0] md_rd
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_md_cnt
`endif
);

  logic [REG_CNT-1:0] r_pending;
  logic [REG_AW-1:0]  r_md_rd;

  logic w_load_use;
  logic w_sb_hit;
  logic w_struct;
  logic w_starve;
  logic w_accept;

  assign w_load_use = load_ex && (rd_ex != '0) && ((rd_ex == rs1_id) || (rd_ex == rs2_id));
  assign w_sb_hit   = (r_pending[rs1_id] && (rs1_id != '0)) ||
                      (r_pending[rs2_id] && (rs2_id != '0)) ||
                      (r_pending[rd_id]  && (rd_id  != '0));
  assign w_struct   = md_op_id && md_busy;

  assign flush    = mispredict_ex;
  assign stall    = !mispredict_ex && (w_load_use || w_sb_hit || w_struct || w_starve);
  assign w_accept = md_op_id && !stall && !flush && (rd_id != '0);

  md_sequencer #(
    .MD_LAT     (MD_LAT),
    .STARVE_LIM (STARVE_LIM)
  ) u_md_seq (
    .clk             (clk),
    .rstn            (rstn),
    .i_accept        (w_accept),
    .i_pipe_wb_valid (pipe_wb_valid),
    .o_md_start      (md_start),
    .o_md_busy       (md_busy),
    .o_md_wb_grant   (md_wb_grant),
    .o_starve        (w_starve)
  );

  // Scoreboard: mark the MUL/DIV destination on accept, clear it when the result is written.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pending <= '0;
      r_md_rd   <= '0;
    end else begin
      if (md_wb_grant) r_pending[r_md_rd] <= 1'b0;
      if (w_accept) begin
        r_pending[rd_id] <= 1'b1;
        r_md_rd          <= rd_id;
      end
    end
  end

  assign md_rd = r_md_rd;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic [31:0] r_perf_md;

  // Event counters for stall cycles, flush cycles and MUL/DIV starts; wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_md    <= '0;
    end else begin
      if (stall)    r_perf_stall <= r_perf_stall + 32'd1;
      if (flush)    r_perf_flush <= r_perf_flush + 32'd1;
      if (w_accept) r_perf_md    <= r_perf_md + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
  assign perf_md_cnt    = r_perf_md;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Randomized self-checking bench for hazard_scheduler against a behavioural model
// built from the hazard rules (scoreboard array, result-ready cycle, denial count).
module tb_hazard_scheduler;

  localparam int LAT = 4;
  localparam int LIM = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] rs1_id, rs2_id, rd_id, rd_ex;
  logic       md_op_id, load_ex, mispredict_ex, pipe_wb_valid;
  logic       stall, flush, md_start, md_busy, md_wb_grant;
  logic [4:0] md_rd;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_md_cnt;
`endif

  always #5 clk = ~clk;

  hazard_scheduler #(
    .MD_LAT     (LAT),
    .STARVE_LIM (LIM)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .rs1_id        (rs1_id),
    .rs2_id        (rs2_id),
    .rd_id         (rd_id),
    .md_op_id      (md_op_id),
    .rd_ex         (rd_ex),
    .load_ex       (load_ex),
    .mispredict_ex (mispredict_ex),
    .pipe_wb_valid (pipe_wb_valid),
    .stall         (stall),
    .flush         (flush),
    .md_start      (md_start),
    .md_busy       (md_busy),
    .md_wb_grant   (md_wb_grant),
    .md_rd         (md_rd)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_md_cnt    (perf_md_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  bit          m_pend [32];
  bit          m_fly;
  int          m_ready;
  int          m_denied;
  logic [4:0]  m_dest;
  int          cyc;
  int unsigned m_nstall, m_nflush, m_nmd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic set_in(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                        input logic op, input logic [4:0] rx, input logic ld,
                        input logic mis, input logic wbv);
    rs1_id = a; rs2_id = b; rd_id = d; md_op_id = op;
    rd_ex = rx; load_ex = ld; mispredict_ex = mis; pipe_wb_valid = wbv;
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_fly = 1'b0; m_ready = 0; m_denied = 0; m_dest = '0;
    m_nstall = 0; m_nflush = 0; m_nmd = 0;
  endtask

  // Called at posedge+1 with inputs driven; checks this cycle, advances model, returns at next posedge+1.
  task automatic step();
    bit lu, hit, st, strv, inres, fl, stl, acc, gr;
    #2;
    inres = m_fly && (cyc >= m_ready);
    lu    = load_ex && (rd_ex != 0) && ((rd_ex == rs1_id) || (rd_ex == rs2_id));
    hit   = ((rs1_id != 0) && m_pend[rs1_id]) || ((rs2_id != 0) && m_pend[rs2_id]) ||
            ((rd_id != 0) && m_pend[rd_id]);
    st    = md_op_id && m_fly;
    strv  = inres && (m_denied >= LIM);
    fl    = mispredict_ex;
    stl   = !fl && (lu || hit || st || strv);
    acc   = md_op_id && !stl && !fl && (rd_id != 0);
    gr    = inres && !pipe_wb_valid;
    chk("stall",       32'(stall),       32'(stl));
    chk("flush",       32'(flush),       32'(fl));
    chk("md_start",    32'(md_start),    32'(acc));
    chk("md_busy",     32'(md_busy),     32'(m_fly));
    chk("md_wb_grant", 32'(md_wb_grant), 32'(gr));
    chk("md_rd",       32'(md_rd),       32'(m_dest));
`ifdef HAZARD_PERF_EN
    chk("perf_stall", perf_stall_cnt, m_nstall);
    chk("perf_flush", perf_flush_cnt, m_nflush);
    chk("perf_md",    perf_md_cnt,    m_nmd);
`endif
    if (stl) m_nstall++;
    if (fl)  m_nflush++;
    if (acc) m_nmd++;
    if (gr) begin
      m_pend[m_dest] = 1'b0;
      m_fly = 1'b0;
    end
    if (inres && pipe_wb_valid && (m_denied < LIM)) m_denied++;
    if (acc) begin
      m_fly = 1'b1; m_ready = cyc + LAT; m_dest = rd_id;
      m_pend[rd_id] = 1'b1; m_denied = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_stall",    32'(stall),       0);
    chk("rst_flush",    32'(flush),       0);
    chk("rst_start",    32'(md_start),    0);
    chk("rst_busy",     32'(md_busy),     0);
    chk("rst_grant",    32'(md_wb_grant), 0);
    chk("rst_md_rd",    32'(md_rd),       0);
`ifdef HAZARD_PERF_EN
    chk("rst_pstall", perf_stall_cnt, 0);
    chk("rst_pflush", perf_flush_cnt, 0);
    chk("rst_pmd",    perf_md_cnt,    0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cyc = 0;
    do_reset();

    // Load-use stall and the rd_ex==0 exemption
    set_in(5, 0, 0, 0, 5, 1, 0, 0); #1; chk("lu_stall", 32'(stall), 1); step();
    set_in(5, 0, 0, 0, 0, 1, 0, 0); #1; chk("lu_rd0",   32'(stall), 0); step();

    // MUL/DIV issue to x7, dependent reader stalls until the grant cycle
    set_in(0, 0, 7, 1, 0, 0, 0, 0); #1; chk("md_start_pulse", 32'(md_start), 1); step();
    for (int i = 0; i < LAT; i++) begin
      set_in(0, 7, 0, 0, 0, 0, 0, 0); #1;
      chk("dep_stall", 32'(stall), 1);
      chk("dep_grant", 32'(md_wb_grant), 32'(i == LAT - 1));
      step();
    end
    set_in(0, 7, 0, 0, 0, 0, 0, 0); #1;
    chk("dep_go", 32'(stall), 0);
    chk("idle_after_grant", 32'(md_busy), 0);
    step();

    // Write-port starvation: WB keeps the port, then releases it
    set_in(0, 0, 7, 1, 0, 0, 0, 0); step();
    for (int i = 0; i < LAT - 1; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1); step();
    end
    for (int i = 0; i <= LIM; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1); #1;
      chk("starve_stall", 32'(stall), 32'(i >= LIM));
      chk("starve_nogrant", 32'(md_wb_grant), 0);
      step();
    end
    set_in(7, 0, 0, 0, 0, 0, 0, 0); #1; chk("late_grant", 32'(md_wb_grant), 1); step();
    set_in(7, 0, 0, 0, 0, 0, 0, 0); #1; chk("sb_cleared", 32'(stall), 0); step();

    // Flush beats load-use and blocks the MUL/DIV start
    set_in(5, 0, 9, 1, 5, 1, 1, 0); #1;
    chk("sim_flush", 32'(flush), 1);
    chk("sim_stall", 32'(stall), 0);
    chk("sim_nostart", 32'(md_start), 0);
    step();

    // Structural and WAW stalls, then reset while BUSY
    set_in(0, 0, 3, 1, 0, 0, 0, 0); step();
    set_in(0, 0, 4, 1, 0, 0, 0, 0); #1; chk("struct_stall", 32'(stall), 1); step();
    set_in(0, 0, 3, 0, 0, 0, 0, 0); #1; chk("waw_stall",    32'(stall), 1); step();
    do_reset();
    set_in(3, 0, 3, 0, 0, 0, 0, 0); #1; chk("rst_sb_clear", 32'(stall), 0); step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      set_in(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 2) != 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Central hazard controller and sequencer for the 5-stage pipeline.
- Generates stall/flush for the IF/ID and ID/EX registers from three sources: load-use hazards, EX-stage branch mispredicts, and a scoreboard for a multi-cycle MUL/DIV unit.
- Sequences the MUL/DIV unit (start, latency count).
- Arbitrates the single register-file write port between the WB stage and the MUL/DIV result.

Parameters:
- MD_LAT, 34: cycles from md_start to result valid; legal range 2..255.
- STARVE_LIM, 4: cycles a pending MUL/DIV result may lose WB arbitration before the pipeline is frozen.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- rs1_id  in  5  ID source reg 1; 0 = unused
- rs2_id  in  5  ID source reg 2; 0 = unused
- rd_id  in  5  ID destination reg
- md_op_id  in  1  ID instruction is MUL/DIV
- rd_ex  in  5  EX destination reg
- load_ex  in  1  EX instruction is a load
- mispredict_ex  in  1  EX branch/jump resolved against prediction
- pipe_wb_valid  in  1  WB stage writes the register file this cycle
- stall  out  1  hold IF/ID, bubble into ID/EX
- flush  out  1  squash IF/ID and ID/EX contents
- md_start  out  1  one-cycle start pulse to MUL/DIV unit
- md_busy  out  1  MUL/DIV FSM not IDLE
- md_wb_grant  out  1  MUL/DIV result owns the write port this cycle
- md_rd  out  5  destination reg of in-flight MUL/DIV

Behaviour:
- Reset (async): FSM=IDLE, scoreboard=0, counters=0, md_rd=0. All outputs 0.
- load_use = load_ex && rd_ex!=0 && (rd_ex==rs1_id || rd_ex==rs2_id).
- sb_hit = any of: pending[rs1_id] with rs1_id!=0; pending[rs2_id] with rs2_id!=0; pending[rd_id] with rd_id!=0 (WAW).
- struct = md_op_id && FSM!=IDLE.
- starve = FSM==RESULT && wait_cnt>=STARVE_LIM.
- stall = !flush && (load_use || sb_hit || struct || starve). Combinational, same cycle.
- flush = mispredict_ex. Combinational. Flush has priority over stall.
- accept = md_op_id && !stall && !flush && rd_id!=0.
  - On accept: md_start=1 the same cycle, md_rd<=rd_id, pending[rd_id]<=1.
  - md_op_id with rd_id==0 is issued to the pipeline but never started.
- FSM states: IDLE, BUSY, RESULT.
  - IDLE -> BUSY on accept; lat_cnt<=MD_LAT-1.
  - BUSY: lat_cnt decrements each cycle; at lat_cnt==0 -> RESULT, wait_cnt<=0.
  - RESULT: md_wb_grant = !pipe_wb_valid (combinational).
    - If granted: pending[md_rd]<=0 and -> IDLE.
    - Otherwise wait_cnt increments, saturating at STARVE_LIM.
- Same-cycle events:
  - Grant and new accept cannot coincide (struct stalls while not IDLE).
  - A dependent instruction in ID during the grant cycle still sees pending=1. It proceeds next cycle; the register file's internal WB bypass covers the write.
- Flush never cancels an in-flight MUL/DIV: it is older than the flushed instructions.
- Only 5-bit indices are used; pending[0] is never set.
- Reset mid-operation abandons the in-flight op. md_start is not reissued.

Optional Feature:
- HAZARD_PERF_EN: adds outputs perf_stall_cnt[31:0], perf_flush_cnt[31:0], perf_md_cnt[31:0].
  - Counts cycles with stall=1, cycles with flush=1, and accepts respectively.
  - Counters wrap modulo 2^32 and reset to 0.
- Without the macro, the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - typedef md_state_t {IDLE, BUSY, RESULT}
  - REG_CNT=32
  - REG_AW=5
- Sub-module md_sequencer: FSM, lat_cnt, wait_cnt, md_start, md_wb_grant.
- The top level holds the hazard equations and the scoreboard.

Test Plan:
- Load-use: load_ex=1, rd_ex=5, rs1_id=5 -> stall=1 for exactly that cycle. With rd_ex=0 -> stall=0.
- MUL/DIV issue, MD_LAT=4:
  - md_op_id=1, rd_id=7 -> md_start pulse, md_busy=1.
  - An instruction in ID with rs2_id=7 stalls until the grant cycle.
  - Grant occurs 4 cycles after start with pipe_wb_valid=0.
- Arbitration: hold pipe_wb_valid=1 in RESULT -> md_wb_grant=0.
  - After 4 cycles stall=1.
  - Drop pipe_wb_valid -> grant=1, pending[7] cleared, FSM=IDLE.
- Simultaneous: mispredict_ex=1 with load_use=1 and md_op_id=1 -> flush=1, stall=0, no md_start.
- Structural/WAW: second md_op_id while BUSY -> stall. ID rd_id equal to the pending reg -> stall.
- Reset: assert rstn=0 in BUSY -> all outputs 0 and scoreboard clear next cycle. Under HAZARD_PERF_EN, counters read 0.
